// File: rtl/snax_hwpe_periph_arbiter.sv
// Round-robin arbiter sharing one HWPE periph port among NumReq requesters, one transaction in flight.
// Optional read-response watchdog enabled by defining SNAX_HWPE_ARB_TIMEOUT_EN.
module snax_hwpe_periph_arbiter #(
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      up_req_i,
    output logic [NumReq-1:0]      up_gnt_o,
    input  logic [NumReq-1:0][31:0] up_add_i,
    input  logic [NumReq-1:0]      up_wen_i,
    input  logic [NumReq-1:0][3:0] up_be_i,
    input  logic [NumReq-1:0][31:0] up_data_i,
    input  logic [NumReq-1:0][4:0] up_id_i,
    output logic [NumReq-1:0]      up_r_valid_o,
    output logic [31:0]            up_r_data_o,
    output logic [4:0]             up_r_id_o,
    output logic                   up_r_err_o,
    output logic                   periph_req_o,
    input  logic                   periph_gnt_i,
    output logic [31:0]            periph_add_o,
    output logic                   periph_wen_o,
    output logic [3:0]             periph_be_o,
    output logic [31:0]            periph_data_o,
    output logic [4:0]             periph_id_o,
    input  logic                   periph_r_valid_i,
    input  logic [31:0]            periph_r_data_i,
    input  logic [4:0]             periph_r_id_i
);

    localparam int IdxW = $clog2(NumReq);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE    = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;

    if (NumReq < 2 || NumReq > 8) begin : g_bad_num_req
        $error("NumReq must be in 2..8");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 1");
    end

    logic [1:0]        state_q;
    logic [IdxW-1:0]   rr_q, owner_q;
    logic [IdxW-1:0]   winner, cand, rr_next;
    logic              any_req;
    logic [NumReq-1:0] owner_oh;
    logic [NumReq-1:0] r_valid_q;
    logic [31:0]       r_data_q;
    logic [4:0]        r_id_q;

`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q;
    logic [4:0]      rd_id_q;
    logic            r_err_q;

    assign up_r_err_o = r_err_q;
`else
    assign up_r_err_o = 1'b0;
`endif

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = IdxW'((int'(rr_q) + k) % NumReq);
            if (!any_req && up_req_i[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    assign rr_next  = IdxW'((int'(winner) + 1) % NumReq);
    assign owner_oh = {{(NumReq-1){1'b0}}, 1'b1} << owner_q;

    // Grant is combinational and forced low while reset is held.
    always_comb begin
        up_gnt_o = '0;
        if (!rst_i && state_q == IDLE && any_req) up_gnt_o[winner] = 1'b1;
    end

    assign periph_req_o = (state_q == ISSUE);
    assign up_r_valid_o = r_valid_q;
    assign up_r_data_o  = r_data_q;
    assign up_r_id_o    = r_id_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            owner_q       <= '0;
            periph_add_o  <= '0;
            periph_wen_o  <= 1'b0;
            periph_be_o   <= '0;
            periph_data_o <= '0;
            periph_id_o   <= '0;
            r_valid_q     <= '0;
            r_data_q      <= '0;
            r_id_q        <= '0;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            rd_id_q       <= '0;
            r_err_q       <= 1'b0;
`endif
        end else begin
            r_valid_q <= '0;
            r_data_q  <= '0;
            r_id_q    <= '0;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
            r_err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        periph_add_o  <= up_add_i[winner];
                        periph_wen_o  <= up_wen_i[winner];
                        periph_be_o   <= up_be_i[winner];
                        periph_data_o <= up_data_i[winner];
                        periph_id_o   <= up_id_i[winner];
                        owner_q       <= winner;
                        rr_q          <= rr_next;
                        state_q       <= ISSUE;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
                        rd_id_q       <= up_id_i[winner];
`endif
                    end
                end
                ISSUE: begin
                    if (periph_gnt_i) begin
                        periph_add_o  <= '0;
                        periph_wen_o  <= 1'b0;
                        periph_be_o   <= '0;
                        periph_data_o <= '0;
                        periph_id_o   <= '0;
                        if (!periph_wen_o) begin
                            state_q <= IDLE;
                        end else if (periph_r_valid_i) begin
                            r_valid_q <= owner_oh;
                            r_data_q  <= periph_r_data_i;
                            r_id_q    <= periph_r_id_i;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= WAIT_RSP;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                WAIT_RSP: begin
                    if (periph_r_valid_i) begin
                        r_valid_q <= owner_oh;
                        r_data_q  <= periph_r_data_i;
                        r_id_q    <= periph_r_id_i;
                        state_q   <= IDLE;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
                    end else if (cnt_q == CntLast) begin
                        // Counter reaches TimeoutCycles on this cycle: answer with an error.
                        r_valid_q <= owner_oh;
                        r_id_q    <= rd_id_q;
                        r_err_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snax_hwpe_periph_arbiter.sv
// Directed self-checking bench for snax_hwpe_periph_arbiter with four requesters.
// Define SNAX_HWPE_ARB_TIMEOUT_EN to also exercise the read watchdog (TimeoutCycles = 8).
module tb_snax_hwpe_periph_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [N-1:0]        up_req, up_gnt, up_wen, up_r_valid;
    logic [N-1:0][31:0]  up_add, up_data;
    logic [N-1:0][3:0]   up_be;
    logic [N-1:0][4:0]   up_id;
    logic [31:0]         up_r_data;
    logic [4:0]          up_r_id;
    logic                up_r_err;
    logic                periph_req, periph_gnt, periph_wen, periph_r_valid;
    logic [31:0]         periph_add, periph_data, periph_r_data;
    logic [3:0]          periph_be;
    logic [4:0]          periph_id, periph_r_id;

    int n_checks = 0;
    int n_pass   = 0;

    snax_hwpe_periph_arbiter #(
        .NumReq        (N),
        .TimeoutCycles (8)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .up_req_i         (up_req),
        .up_gnt_o         (up_gnt),
        .up_add_i         (up_add),
        .up_wen_i         (up_wen),
        .up_be_i          (up_be),
        .up_data_i        (up_data),
        .up_id_i          (up_id),
        .up_r_valid_o     (up_r_valid),
        .up_r_data_o      (up_r_data),
        .up_r_id_o        (up_r_id),
        .up_r_err_o       (up_r_err),
        .periph_req_o     (periph_req),
        .periph_gnt_i     (periph_gnt),
        .periph_add_o     (periph_add),
        .periph_wen_o     (periph_wen),
        .periph_be_o      (periph_be),
        .periph_data_o    (periph_data),
        .periph_id_o      (periph_id),
        .periph_r_valid_i (periph_r_valid),
        .periph_r_data_i  (periph_r_data),
        .periph_r_id_i    (periph_r_id)
    );

    task clear_inputs();
        up_req         = '0;
        up_wen         = '0;
        up_add         = '0;
        up_data        = '0;
        up_be          = '0;
        up_id          = '0;
        periph_gnt     = 1'b0;
        periph_r_valid = 1'b0;
        periph_r_data  = '0;
        periph_r_id    = '0;
    endtask

    task test_reset();
        rst = 1'b1;
        clear_inputs();
        up_req = 4'b0001;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (up_gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", up_gnt); else n_pass++;
        n_checks++;
        if (periph_req !== 1'b0) $display("FAIL rst_periph_req: got %b want 0", periph_req); else n_pass++;
        n_checks++;
        if (periph_add !== 32'h0) $display("FAIL rst_periph_add: got %h want 0", periph_add); else n_pass++;
        n_checks++;
        if (up_r_valid !== 4'b0000 || up_r_err !== 1'b0)
            $display("FAIL rst_resp: got valid %b err %b want 0000 0", up_r_valid, up_r_err);
        else n_pass++;
        @(negedge clk);
        rst    = 1'b0;
        up_req = '0;
    endtask

    task test_single_write();
        @(negedge clk);
        up_req[0]  = 1'b1;
        up_wen[0]  = 1'b0;
        up_add[0]  = 32'h10;
        up_data[0] = 32'hDEADBEEF;
        up_be[0]   = 4'hF;
        up_id[0]   = 5'd3;
        #1;
        n_checks++;
        if (up_gnt !== 4'b0001 || periph_req !== 1'b0)
            $display("FAIL wr_grant: got gnt %b req %b want 0001 0", up_gnt, periph_req);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            up_req     = '0;
            periph_gnt = (i == 2);
            #1;
            n_checks++;
            if (periph_req !== 1'b1 || periph_add !== 32'h10 || periph_data !== 32'hDEADBEEF ||
                periph_be !== 4'hF || periph_wen !== 1'b0 || up_gnt !== 4'b0000)
                $display("FAIL wr_issue%0d: got req %b add %h data %h be %h wen %b gnt %b want 1 10 deadbeef f 0 0000",
                         i, periph_req, periph_add, periph_data, periph_be, periph_wen, up_gnt);
            else n_pass++;
            n_checks++;
            if (up_r_valid !== 4'b0000) $display("FAIL wr_no_rsp%0d: got %b want 0000", i, up_r_valid); else n_pass++;
        end
        @(negedge clk);
        periph_gnt = 1'b0;
        #1;
        n_checks++;
        if (periph_req !== 1'b0 || periph_add !== 32'h0 || periph_data !== 32'h0)
            $display("FAIL wr_done: got req %b add %h data %h want 0 0 0", periph_req, periph_add, periph_data);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (up_r_valid !== 4'b0000) $display("FAIL wr_no_rsp_after: got %b want 0000", up_r_valid); else n_pass++;
    endtask

    task test_read_routing();
        @(negedge clk);
        clear_inputs();
        up_req[1] = 1'b1;
        up_wen[1] = 1'b1;
        up_add[1] = 32'h20;
        up_id[1]  = 5'd5;
        #1;
        n_checks++;
        if (up_gnt !== 4'b0010) $display("FAIL rd_grant: got %b want 0010", up_gnt); else n_pass++;
        @(negedge clk);
        up_req     = '0;
        periph_gnt = 1'b1;
        #1;
        n_checks++;
        if (periph_req !== 1'b1 || periph_wen !== 1'b1 || periph_id !== 5'd5 || periph_add !== 32'h20)
            $display("FAIL rd_issue: got req %b wen %b id %0d add %h want 1 1 5 20", periph_req, periph_wen, periph_id, periph_add);
        else n_pass++;
        @(negedge clk);
        periph_gnt = 1'b0;
        #1;
        n_checks++;
        if (periph_req !== 1'b0 || up_r_valid !== 4'b0000)
            $display("FAIL rd_wait: got req %b valid %b want 0 0000", periph_req, up_r_valid);
        else n_pass++;
        @(negedge clk);
        periph_r_valid = 1'b1;
        periph_r_data  = 32'h1234;
        periph_r_id    = 5'd5;
        #1;
        n_checks++;
        if (up_r_valid !== 4'b0000) $display("FAIL rd_early: got %b want 0000", up_r_valid); else n_pass++;
        @(negedge clk);
        periph_r_valid = 1'b0;
        periph_r_data  = '0;
        periph_r_id    = '0;
        #1;
        n_checks++;
        if (up_r_valid !== 4'b0010 || up_r_data !== 32'h1234 || up_r_id !== 5'd5 || up_r_err !== 1'b0)
            $display("FAIL rd_rsp: got valid %b data %h id %0d err %b want 0010 1234 5 0", up_r_valid, up_r_data, up_r_id, up_r_err);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (up_r_valid !== 4'b0000 || up_r_data !== 32'h0 || up_r_id !== 5'd0)
            $display("FAIL rd_rsp_clear: got valid %b data %h id %0d want 0000 0 0", up_r_valid, up_r_data, up_r_id);
        else n_pass++;
    endtask

    task test_contention();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_inputs();
        up_req     = 4'hF;
        periph_gnt = 1'b1;
        for (int i = 0; i < N; i++) up_add[i] = 32'h100 + i;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_checks++;
            if (c % 2 == 0) begin
                if (up_gnt !== (4'b0001 << exp_order[c/2]))
                    $display("FAIL rr_grant%0d: got %b want %b", c/2, up_gnt, 4'b0001 << exp_order[c/2]);
                else n_pass++;
            end else begin
                if (up_gnt !== 4'b0000 || periph_req !== 1'b1 || periph_add !== 32'h100 + exp_order[c/2])
                    $display("FAIL rr_issue%0d: got gnt %b req %b add %h want 0000 1 %h",
                             c/2, up_gnt, periph_req, periph_add, 32'h100 + exp_order[c/2]);
                else n_pass++;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task test_same_cycle();
        @(negedge clk);
        up_req[2] = 1'b1;
        up_wen[2] = 1'b1;
        up_add[2] = 32'h30;
        up_id[2]  = 5'd7;
        #1;
        n_checks++;
        if (up_gnt !== 4'b0100) $display("FAIL sc_grant: got %b want 0100", up_gnt); else n_pass++;
        @(negedge clk);
        up_req         = '0;
        periph_gnt     = 1'b1;
        periph_r_valid = 1'b1;
        periph_r_data  = 32'hCAFE0001;
        periph_r_id    = 5'd7;
        #1;
        n_checks++;
        if (periph_req !== 1'b1) $display("FAIL sc_issue: got %b want 1", periph_req); else n_pass++;
        @(negedge clk);
        clear_inputs();
        up_req[3] = 1'b1;
        up_add[3] = 32'h40;
        #1;
        n_checks++;
        if (up_r_valid !== 4'b0100 || up_r_data !== 32'hCAFE0001 || up_r_id !== 5'd7)
            $display("FAIL sc_rsp: got valid %b data %h id %0d want 0100 cafe0001 7", up_r_valid, up_r_data, up_r_id);
        else n_pass++;
        n_checks++;
        if (up_gnt !== 4'b1000 || periph_req !== 1'b0)
            $display("FAIL sc_no_hang: got gnt %b req %b want 1000 0", up_gnt, periph_req);
        else n_pass++;
        @(negedge clk);
        up_req     = '0;
        periph_gnt = 1'b1;
        #1;
        n_checks++;
        if (periph_add !== 32'h40 || up_r_valid !== 4'b0000)
            $display("FAIL sc_next_issue: got add %h valid %b want 40 0000", periph_add, up_r_valid);
        else n_pass++;
        @(negedge clk);
        periph_gnt = 1'b0;
    endtask

    task test_reset_mid_read();
        @(negedge clk);
        clear_inputs();
        up_req[1] = 1'b1;
        up_wen[1] = 1'b1;
        up_id[1]  = 5'd12;
        #1;
        n_checks++;
        if (up_gnt !== 4'b0010) $display("FAIL rmr_grant: got %b want 0010", up_gnt); else n_pass++;
        @(negedge clk);
        up_req     = '0;
        periph_gnt = 1'b1;
        @(negedge clk);
        periph_gnt = 1'b0;
        rst        = 1'b1;
        up_req     = 4'b0100;
        #1;
        n_checks++;
        if (up_gnt !== 4'b0000 || periph_req !== 1'b0 || up_r_valid !== 4'b0000 ||
            periph_add !== 32'h0 || periph_id !== 5'd0 || up_r_data !== 32'h0)
            $display("FAIL rmr_outputs: got gnt %b req %b valid %b add %h id %0d rdata %h want all 0",
                     up_gnt, periph_req, up_r_valid, periph_add, periph_id, up_r_data);
        else n_pass++;
        @(negedge clk);
        rst            = 1'b0;
        up_wen         = '0;
        up_req         = 4'b0101;
        periph_r_valid = 1'b1;
        periph_r_data  = 32'hBAD;
        periph_r_id    = 5'd12;
        #1;
        n_checks++;
        if (up_gnt !== 4'b0001) $display("FAIL rmr_rr_restart: got %b want 0001", up_gnt); else n_pass++;
        @(negedge clk);
        clear_inputs();
        periph_gnt = 1'b1;
        #1;
        n_checks++;
        if (up_r_valid !== 4'b0000 || periph_req !== 1'b1)
            $display("FAIL rmr_stale_rsp: got valid %b req %b want 0000 1", up_r_valid, periph_req);
        else n_pass++;
        @(negedge clk);
        periph_gnt = 1'b0;
    endtask

`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
    task test_timeout();
        @(negedge clk);
        clear_inputs();
        up_req[3] = 1'b1;
        up_wen[3] = 1'b1;
        up_id[3]  = 5'd9;
        #1;
        n_checks++;
        if (up_gnt !== 4'b1000) $display("FAIL to_grant: got %b want 1000", up_gnt); else n_pass++;
        @(negedge clk);
        up_req     = '0;
        periph_gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            periph_gnt = 1'b0;
            #1;
            n_checks++;
            if (up_r_valid !== 4'b0000) $display("FAIL to_early%0d: got %b want 0000", k, up_r_valid); else n_pass++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (up_r_valid !== 4'b1000 || up_r_err !== 1'b1 || up_r_id !== 5'd9 || up_r_data !== 32'h0)
            $display("FAIL to_rsp: got valid %b err %b id %0d data %h want 1000 1 9 0", up_r_valid, up_r_err, up_r_id, up_r_data);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (up_r_valid !== 4'b0000 || up_r_err !== 1'b0)
            $display("FAIL to_clear: got valid %b err %b want 0000 0", up_r_valid, up_r_err);
        else n_pass++;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_routing();
        test_contention();
        test_same_cycle();
        test_reset_mid_read();
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
